// File: rtl/secuenciador_motor_pkg.sv
// Shared definitions for the two-axis stepper sequencer: direction codes, axis states, coil tables.
// Define MEDIO_PASO_EN to build the 8-entry half-step table instead of the 4-entry full-step one.
package secuenciador_motor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSA = 2'd2
    } estado_t;

    localparam logic [1:0] PARAR       = 2'b00;
    localparam logic [1:0] HORARIO     = 2'b01;
    localparam logic [1:0] ANTIHORARIO = 2'b11;

`ifdef MEDIO_PASO_EN
    localparam int FASES = 8;
`else
    localparam int FASES = 4;
`endif
    localparam int FASE_W = $clog2(FASES);

    // Code 10 is not a motion request; it behaves exactly like PARAR.
    function automatic logic es_marcha(input logic [1:0] code);
        return (code == HORARIO) || (code == ANTIHORARIO);
    endfunction

    function automatic logic [3:0] bobinas_de_fase(input logic [FASE_W-1:0] idx);
        logic [3:0] patron;
`ifdef MEDIO_PASO_EN
        case (idx)
            3'd0:    patron = 4'b1000;
            3'd1:    patron = 4'b1100;
            3'd2:    patron = 4'b0100;
            3'd3:    patron = 4'b0110;
            3'd4:    patron = 4'b0010;
            3'd5:    patron = 4'b0011;
            3'd6:    patron = 4'b0001;
            default: patron = 4'b1001;
        endcase
`else
        case (idx)
            2'd0:    patron = 4'b1100;
            2'd1:    patron = 4'b0110;
            2'd2:    patron = 4'b0011;
            default: patron = 4'b1001;
        endcase
`endif
        return patron;
    endfunction

endpackage

// File: rtl/eje_paso.sv
// One stepper axis: input code register, tick prescaler, IDLE/RUN/PAUSA FSM, phase index and position.
// The coil table (full or half step) comes from the package, selected by MEDIO_PASO_EN.
module eje_paso
    import secuenciador_motor_pkg::*;
#(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  s_in,
    output logic [3:0]  bobinas,
    output logic [15:0] pos,
    output logic        busy
);

    estado_t           estado, estado_n;
    logic [1:0]        code_q;
    logic [1:0]        dir, dir_n;
    logic [15:0]       cuenta, cuenta_n;
    logic [7:0]        muerto, muerto_n;
    logic [FASE_W-1:0] fase, fase_n;
    logic [15:0]       pos_n;
    logic [3:0]        bobinas_n;
    logic              tick;
    logic              paso;

    assign tick = (estado != IDLE) && (cuenta == 16'(DIV - 1));
    assign busy = (estado != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        estado_n  = estado;
        dir_n     = dir;
        muerto_n  = muerto;
        fase_n    = fase;
        pos_n     = pos;
        bobinas_n = bobinas;
        paso      = 1'b0;

        case (estado)
            IDLE: begin
                if (es_marcha(code_q)) begin
                    estado_n = RUN;
                    dir_n    = code_q;
                end
            end
            RUN: begin
                if (!es_marcha(code_q)) begin
                    estado_n = IDLE;
                end else if (code_q != dir) begin
                    estado_n = PAUSA;
                    dir_n    = code_q;
                    muerto_n = 8'(DEAD);
                end else if (tick) begin
                    paso = 1'b1;
                end
            end
            PAUSA: begin
                if (!es_marcha(code_q)) begin
                    estado_n = IDLE;
                end else if (code_q != dir) begin
                    dir_n    = code_q;
                    muerto_n = 8'(DEAD);
                end else if (tick) begin
                    // The tick that empties the dead counter only re-enters RUN; stepping waits for the next one.
                    if (muerto <= 8'd1) begin
                        muerto_n = 8'd0;
                        estado_n = RUN;
                    end else begin
                        muerto_n = muerto - 8'd1;
                    end
                end
            end
            default: estado_n = IDLE;
        endcase

        // Forward drives the pattern at the index and then advances; reverse retreats first and drives that.
        if (paso) begin
            if (dir == HORARIO) begin
                bobinas_n = bobinas_de_fase(fase);
                fase_n    = fase + 1'b1;
                pos_n     = pos + 16'd1;
            end else begin
                fase_n    = fase - 1'b1;
                bobinas_n = bobinas_de_fase(fase_n);
                pos_n     = pos - 16'd1;
            end
        end

        if (estado_n != RUN) begin
            bobinas_n = 4'b0000;
        end

        if ((estado == IDLE) || (estado_n == IDLE) || tick) begin
            cuenta_n = 16'd0;
        end else begin
            cuenta_n = cuenta + 16'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado  <= IDLE;
            code_q  <= PARAR;
            dir     <= PARAR;
            cuenta  <= 16'd0;
            muerto  <= 8'd0;
            fase    <= '0;
            pos     <= 16'd0;
            bobinas <= 4'b0000;
        end else begin
            estado  <= estado_n;
            code_q  <= s_in;
            dir     <= dir_n;
            cuenta  <= cuenta_n;
            muerto  <= muerto_n;
            fase    <= fase_n;
            pos     <= pos_n;
            bobinas <= bobinas_n;
        end
    end

endmodule

// File: rtl/secuenciador_motor.sv
// Two-axis (theta/phi) stepper sequencer built from two independent eje_paso instances.
// Define MEDIO_PASO_EN for half-step drive; the default build uses full-step drive.
module secuenciador_motor
    import secuenciador_motor_pkg::*;
#(
    parameter int unsigned DIV  = 50000,
    parameter int unsigned DEAD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  s_in_theta,
    input  logic [1:0]  s_in_phi,
    output logic [3:0]  bobinas_theta,
    output logic [3:0]  bobinas_phi,
    output logic [15:0] pos_theta,
    output logic [15:0] pos_phi,
    output logic        busy
);

    logic busy_theta;
    logic busy_phi;

    eje_paso #(.DIV(DIV), .DEAD(DEAD)) u_eje_theta (
        .clk     (clk),
        .rst     (rst),
        .s_in    (s_in_theta),
        .bobinas (bobinas_theta),
        .pos     (pos_theta),
        .busy    (busy_theta)
    );

    eje_paso #(.DIV(DIV), .DEAD(DEAD)) u_eje_phi (
        .clk     (clk),
        .rst     (rst),
        .s_in    (s_in_phi),
        .bobinas (bobinas_phi),
        .pos     (pos_phi),
        .busy    (busy_phi)
    );

    assign busy = busy_theta | busy_phi;

endmodule
